// File: rtl/rams16_port_arbiter.sv
// rams16_port_arbiter
//   Shares one single-port 16-deep distributed RAM (WIDTH X_RAMS16 cells with a
//   common address, asynchronous read and write on the rising clock edge)
//   between two requesters A and B. Round-robin, one access per cycle.
//
//   Optional feature macro: RAMS16_ARB_CLEAR_EN
//     defined     : after reset a clear sequencer writes CLR_VALUE to addresses
//                   0..15 (BUSY=1, no grants) before arbitration starts.
//     not defined : arbitration starts in the first cycle after reset release,
//                   BUSY is tied 0 and the RAM keeps its INIT contents.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_req/a_we/a_adr/a_di      requester A; held stable until a_gnt
//   a_gnt                      combinational grant, access happens this cycle
//   a_do/a_do_vld              registered read data, one-cycle valid pulse
//   b_*                        identical set for requester B
//   ram_adr/ram_we/ram_di      to ADR3..0 / WE / I of the RAM cells
//   ram_do                     from O of the RAM cells (asynchronous read)
//   busy                       1 while the clear sequence runs
module rams16_port_arbiter #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [3:0]       a_adr,
  input  logic [WIDTH-1:0] a_di,
  output logic             a_gnt,
  output logic [WIDTH-1:0] a_do,
  output logic             a_do_vld,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [3:0]       b_adr,
  input  logic [WIDTH-1:0] b_di,
  output logic             b_gnt,
  output logic [WIDTH-1:0] b_do,
  output logic             b_do_vld,
  output logic [3:0]       ram_adr,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_di,
  input  logic [WIDTH-1:0] ram_do,
  output logic             busy
);

  logic       prio_b;    // 1: B wins when both request
  logic       run;       // arbitration enabled
  logic       clearing;  // clear sequencer owns the RAM
  logic [3:0] clr_adr;

`ifdef RAMS16_ARB_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t     state, state_next;
  logic [3:0] clr_cnt, clr_cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= 4'h0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // Walk 0..15 once; leave after the cycle that writes address 15.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    if (state == ST_CLEAR) begin
      clr_cnt_next = clr_cnt + 4'd1;
      if (clr_cnt == 4'hF) begin
        state_next = ST_RUN;
      end
    end
  end

  assign run      = (state == ST_RUN);
  assign clearing = (state == ST_CLEAR);
  assign busy     = clearing;
  assign clr_adr  = clr_cnt;
`else
  assign run      = 1'b1;
  assign clearing = 1'b0;
  assign busy     = 1'b0;
  assign clr_adr  = 4'h0;
`endif

  // Grants and RAM drive. rst_n gates everything so that a write in flight
  // when reset is asserted never reaches the RAM's write edge.
  always_comb begin
    a_gnt   = 1'b0;
    b_gnt   = 1'b0;
    ram_adr = 4'h0;
    ram_we  = 1'b0;
    ram_di  = '0;
    if (rst_n && run) begin
      if (a_req && (!b_req || !prio_b)) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
    end
    if (rst_n && clearing) begin
      ram_adr = clr_adr;
      ram_we  = 1'b1;
      ram_di  = CLR_VALUE;
    end else if (a_gnt) begin
      ram_adr = a_adr;
      ram_we  = a_we;
      ram_di  = a_di;
    end else if (b_gnt) begin
      ram_adr = b_adr;
      ram_we  = b_we;
      ram_di  = b_di;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_b   <= 1'b0;
      a_do     <= '0;
      a_do_vld <= 1'b0;
      b_do     <= '0;
      b_do_vld <= 1'b0;
    end else begin
      // Priority flips to the loser after each grant; idle cycles keep it.
      if (a_gnt) begin
        prio_b <= 1'b1;
      end else if (b_gnt) begin
        prio_b <= 1'b0;
      end
      a_do_vld <= a_gnt & ~a_we;
      b_do_vld <= b_gnt & ~b_we;
      if (a_gnt && !a_we) begin
        a_do <= ram_do;
      end
      if (b_gnt && !b_we) begin
        b_do <= ram_do;
      end
    end
  end

endmodule

// File: tb/tb_rams16_port_arbiter.sv
// tb_rams16_port_arbiter
//   Scoreboard bench for rams16_port_arbiter with an external RAM model.
//   A driver process issues requester operations from per-side queues and
//   predicts grants and RAM drive from the round-robin rules; predicted read
//   data is pushed to per-side queues which a separate monitor pops whenever
//   DO_VLD is seen. Honours RAMS16_ARB_CLEAR_EN like the design.
module tb_rams16_port_arbiter;

`ifdef RAMS16_ARB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       a_req, a_we, b_req, b_we;
  logic [3:0] a_adr, b_adr;
  logic [7:0] a_di, b_di;
  logic       a_gnt, b_gnt, a_do_vld, b_do_vld;
  logic [7:0] a_do, b_do;
  logic [3:0] ram_adr;
  logic       ram_we;
  logic [7:0] ram_di, ram_do;
  logic       busy;

  rams16_port_arbiter #(.WIDTH(8), .CLR_VALUE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_di(a_di),
    .a_gnt(a_gnt), .a_do(a_do), .a_do_vld(a_do_vld),
    .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_di(b_di),
    .b_gnt(b_gnt), .b_do(b_do), .b_do_vld(b_do_vld),
    .ram_adr(ram_adr), .ram_we(ram_we), .ram_di(ram_di), .ram_do(ram_do),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // RAM model: asynchronous read, write on rising edge, INIT image loadable.
  logic [7:0] hw_mem   [16];
  logic [7:0] init_img [16];
  bit         load_en = 1'b1;
  assign ram_do = hw_mem[ram_adr];
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 16; i++) hw_mem[i] <= init_img[i];
    end else if (ram_we) begin
      hw_mem[ram_adr] <= ram_di;
    end
  end

  typedef struct {
    bit         we;
    logic [3:0] adr;
    logic [7:0] di;
    int         gap;
  } op_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;

  op_t  aq[$], bq[$];
  exp_t a_exp[$], b_exp[$];

  logic [7:0] ref_mem [16];
  bit  prio_b  = 1'b0;   // which side wins a tie
  int  clr_left = 0;     // clear cycles still expected
  int  a_wait = 0, b_wait = 0;
  int  checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic op_t mk(input bit we, input logic [3:0] adr, input logic [7:0] di, input int gap);
    op_t o;
    o.we = we; o.adr = adr; o.di = di; o.gap = gap;
    return o;
  endfunction

  // Apply the predicted access to the reference memory and scoreboard.
  task automatic retire(input bit side_b);
    op_t  o;
    exp_t e;
    o = side_b ? bq.pop_front() : aq.pop_front();
    if (o.we) begin
      ref_mem[o.adr] = o.di;
      $display("cycle %0d %s write adr=%0d data=%02h", cyc, side_b ? "B" : "A", o.adr, o.di);
    end else begin
      e.cyc  = cyc + 1;
      e.data = ref_mem[o.adr];
      if (side_b) b_exp.push_back(e); else a_exp.push_back(e);
      $display("cycle %0d %s read  adr=%0d expect=%02h", cyc, side_b ? "B" : "A", o.adr, e.data);
    end
    if (side_b) b_wait = (bq.size() > 0) ? bq[0].gap : 0;
    else        a_wait = (aq.size() > 0) ? aq[0].gap : 0;
    prio_b = !side_b;
  endtask

  task automatic check_cycle();
    bit         ea, eb, ewe, ebusy;
    logic [3:0] eadr;
    logic [7:0] edi;
    ea = 0; eb = 0; ewe = 0; eadr = 4'h0; edi = 8'h00; ebusy = 0;
    if (!rst_n) begin
      ebusy = CLR_EN;
    end else if (clr_left > 0) begin
      ebusy = 1; ewe = 1; eadr = 4'(16 - clr_left); edi = 8'h00;
      clr_left--;
    end else begin
      if (a_req && (!b_req || !prio_b)) ea = 1;
      else if (b_req) eb = 1;
      if (ea) begin eadr = a_adr; ewe = a_we; edi = a_di; end
      if (eb) begin eadr = b_adr; ewe = b_we; edi = b_di; end
    end
    chk("a_gnt",   32'(a_gnt),   32'(ea));
    chk("b_gnt",   32'(b_gnt),   32'(eb));
    chk("busy",    32'(busy),    32'(ebusy));
    chk("ram_we",  32'(ram_we),  32'(ewe));
    chk("ram_adr", 32'(ram_adr), 32'(eadr));
    chk("ram_di",  32'(ram_di),  32'(edi));
    if (ea) retire(1'b0);
    if (eb) retire(1'b1);
  endtask

  // One clock cycle: optional reset release, drive requests, optional
  // mid-cycle reset assertion, then check at the falling edge.
  task automatic step(input bit rel, input bit rst_mid);
    @(posedge clk);
    #1;
    if (rel) begin
      rst_n    = 1'b1;
      load_en  = 1'b0;
      clr_left = CLR_EN ? 16 : 0;
      if (CLR_EN) for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    end
    a_req = 0; b_req = 0;
    if (aq.size() > 0 && a_wait > 0) a_wait--;
    else if (aq.size() > 0) begin
      a_req = 1; a_we = aq[0].we; a_adr = aq[0].adr; a_di = aq[0].di;
    end
    if (bq.size() > 0 && b_wait > 0) b_wait--;
    else if (bq.size() > 0) begin
      b_req = 1; b_we = bq[0].we; b_adr = bq[0].adr; b_di = bq[0].di;
    end
    if (rst_mid) begin
      #1;
      rst_n = 1'b0;
    end
    @(negedge clk);
    check_cycle();
    if (!rst_n) begin
      prio_b = 1'b0;
      clr_left = 0;
    end
    if (rst_mid) begin
      aq.delete(); bq.delete(); a_exp.delete(); b_exp.delete();
      a_wait = 0; b_wait = 0;
    end
  endtask

  task automatic run_until_empty(input int limit);
    int n = 0;
    while ((aq.size() > 0 || bq.size() > 0) && n < limit) begin
      step(1'b0, 1'b0);
      n++;
    end
    chk("drain_timeout", 32'(aq.size() + bq.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever a DO_VLD pulse is seen.
  logic [7:0] a_last = 8'h00, b_last = 8'h00;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("a_do_vld_rst", 32'(a_do_vld), 32'd0);
      chk("b_do_vld_rst", 32'(b_do_vld), 32'd0);
      chk("a_do_rst",     32'(a_do),     32'd0);
      chk("b_do_rst",     32'(b_do),     32'd0);
      a_last = 8'h00;
      b_last = 8'h00;
    end else begin
      if (a_do_vld) begin
        if (a_exp.size() == 0) chk("a_do_vld_spurious", 32'(a_do_vld), 32'd0);
        else begin
          e = a_exp.pop_front();
          chk("a_do",      32'(a_do), 32'(e.data));
          chk("a_latency", 32'(cyc),  32'(e.cyc));
          a_last = e.data;
        end
      end else begin
        chk("a_do_hold", 32'(a_do), 32'(a_last));
        if (a_exp.size() > 0 && a_exp[0].cyc <= cyc) begin
          chk("a_do_vld_missing", 32'(a_do_vld), 32'd1);
          void'(a_exp.pop_front());
        end
      end
      if (b_do_vld) begin
        if (b_exp.size() == 0) chk("b_do_vld_spurious", 32'(b_do_vld), 32'd0);
        else begin
          e = b_exp.pop_front();
          chk("b_do",      32'(b_do), 32'(e.data));
          chk("b_latency", 32'(cyc),  32'(e.cyc));
          b_last = e.data;
        end
      end else begin
        chk("b_do_hold", 32'(b_do), 32'(b_last));
        if (b_exp.size() > 0 && b_exp[0].cyc <= cyc) begin
          chk("b_do_vld_missing", 32'(b_do_vld), 32'd1);
          void'(b_exp.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_adr = 0; a_di = 0;
    b_req = 0; b_we = 0; b_adr = 0; b_di = 0;
    // INIT image: bit 0 set only at address 0, other bits random.
    for (int i = 0; i < 16; i++) begin
      init_img[i] = 8'($urandom) & 8'hFE;
      if (i == 0) init_img[i][0] = 1'b1;
      ref_mem[i] = init_img[i];
    end

    // A holds read requests through reset (and the clear sequence if any).
    aq.push_back(mk(0, 4'd0, 8'h00, 0));
    aq.push_back(mk(0, 4'd5, 8'h00, 0));
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    run_until_empty(40);
    repeat (2) step(1'b0, 1'b0);

    // Write then immediate read of the same address from the other side.
    aq.push_back(mk(1, 4'd3, 8'hA5, 0));
    run_until_empty(10);
    bq.push_back(mk(0, 4'd3, 8'h00, 0));
    run_until_empty(10);
    repeat (2) step(1'b0, 1'b0);

    // Both sides held: alternating grants.
    for (int i = 0; i < 3; i++) begin
      aq.push_back(mk(0, 4'($urandom_range(0, 15)), 8'h00, 0));
      bq.push_back(mk(0, 4'($urandom_range(0, 15)), 8'h00, 0));
    end
    run_until_empty(20);

    // B alone, address wrapping 15 -> 0.
    bq.push_back(mk(0, 4'd15, 8'h00, 0));
    bq.push_back(mk(0, 4'd0,  8'h00, 0));
    bq.push_back(mk(0, 4'd1,  8'h00, 0));
    bq.push_back(mk(0, 4'd2,  8'h00, 0));
    run_until_empty(10);
    repeat (2) step(1'b0, 1'b0);

    // Random mixed traffic with idle gaps.
    for (int i = 0; i < 120; i++) begin
      op_t o;
      o = mk(1'($urandom), 4'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) bq.push_back(o); else aq.push_back(o);
    end
    run_until_empty(1000);
    repeat (2) step(1'b0, 1'b0);

    // Reset asserted during an A write: must not be committed.
    aq.push_back(mk(1, 4'd7, 8'h3C, 0));
    if (ref_mem[7] == 8'h3C) ref_mem[7] = 8'h3C;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    aq.push_back(mk(0, 4'd7, 8'h00, 0));
    run_until_empty(40);
    repeat (3) step(1'b0, 1'b0);

    chk("scoreboard_empty", 32'(a_exp.size() + b_exp.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
